// File: rtl/xilinx_status_led_pkg.sv
// Shared types and constants for the status LED controller.
package xilinx_status_led_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'b00,
        ON        = 2'b01,
        HEARTBEAT = 2'b10,
        STATUS    = 2'b11
    } led_mode_e;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        PASS     = 3'd1,
        FAIL_ON  = 3'd2,
        FAIL_OFF = 3'd3,
        FAIL_GAP = 3'd4
    } status_state_e;

    localparam int unsigned FAIL_GAP_TICKS = 4;

endpackage

// File: rtl/xilinx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module xilinx_sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/xilinx_status_led_ctrl.sv
// Status LED controller: heartbeat, per-channel mode select and a
// pass/fail blink code derived from a captured program exit value.
module xilinx_status_led_ctrl #(
    parameter int unsigned NUM_LEDS     = 4,
    parameter int unsigned PRESCALE_W   = 24,
    parameter int unsigned HB_TICKS     = 8,
    parameter int unsigned EXIT_VALUE_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [2*NUM_LEDS-1:0]   led_mode_i,
    input  logic                    exit_valid_i,
    input  logic [EXIT_VALUE_W-1:0] exit_value_i,
    output logic [NUM_LEDS-1:0]     led_o,
    output logic                    exit_captured_o,
    output logic [EXIT_VALUE_W-1:0] exit_value_o
);

    import xilinx_status_led_pkg::*;

    localparam logic [7:0] HbLast  = 8'(HB_TICKS - 1);
    localparam logic [2:0] GapLast = 3'(FAIL_GAP_TICKS - 1);

    // Prescaler and heartbeat
    logic [PRESCALE_W-1:0] presc_q;
    logic                  tick;
    logic [7:0]            hb_cnt_q;
    logic                  hb_q;

    assign tick = &presc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q  <= '0;
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            presc_q <= presc_q + PRESCALE_W'(1);
            if (tick) begin
                if (hb_cnt_q == HbLast) begin
                    hb_cnt_q <= '0;
                    hb_q     <= ~hb_q;
                end else begin
                    hb_cnt_q <= hb_cnt_q + 8'd1;
                end
            end
        end
    end

    // Exit capture
    logic                    exit_sync;
    logic                    exit_prev_q;
    logic                    exit_rise;
    logic                    captured_q;
    logic [EXIT_VALUE_W-1:0] value_q;

    xilinx_sync_2ff #(
        .RESET_VALUE (1'b0)
    ) u_exit_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (exit_valid_i),
        .q_o    (exit_sync)
    );

    assign exit_rise = exit_sync & ~exit_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_prev_q <= 1'b0;
            captured_q  <= 1'b0;
            value_q     <= '0;
        end else begin
            exit_prev_q <= exit_sync;
            if (exit_rise && !captured_q) begin
                captured_q <= 1'b1;
                value_q    <= exit_value_i;
            end
        end
    end

    assign exit_captured_o = captured_q;
    assign exit_value_o    = value_q;

    // Status FSM
    status_state_e state_q, state_d;
    logic [4:0]    pulse_cnt_q, pulse_cnt_d;
    logic [2:0]    gap_cnt_q, gap_cnt_d;
    logic [4:0]    blink_n;
    logic          status_led;

    // A zero low nibble on a non-zero value means the longest code, 16 pulses.
    assign blink_n = (value_q[3:0] == 4'd0) ? 5'd16 : {1'b0, value_q[3:0]};

    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            RUN: begin
                if (captured_q) begin
                    state_d = (value_q == '0) ? PASS : FAIL_ON;
                end
            end
            PASS: state_d = PASS;
            FAIL_ON: begin
                if (tick) begin
                    state_d     = FAIL_OFF;
                    pulse_cnt_d = pulse_cnt_q + 5'd1;
                end
            end
            FAIL_OFF: begin
                if (tick) begin
                    state_d = (pulse_cnt_q < blink_n) ? FAIL_ON : FAIL_GAP;
                end
            end
            FAIL_GAP: begin
                if (tick) begin
                    if (gap_cnt_q == GapLast) begin
                        state_d     = FAIL_ON;
                        gap_cnt_d   = '0;
                        pulse_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            pulse_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    always_comb begin
        case (state_q)
            RUN:           status_led = hb_q;
            PASS, FAIL_ON: status_led = 1'b1;
            default:       status_led = 1'b0;
        endcase
    end

    // LED output registers
    logic [NUM_LEDS-1:0] led_d;
    logic [NUM_LEDS-1:0] led_q;

    always_comb begin
        led_d = '0;
        for (int n = 0; n < int'(NUM_LEDS); n++) begin
            case (led_mode_e'(led_mode_i[2*n +: 2]))
                OFF:       led_d[n] = 1'b0;
                ON:        led_d[n] = 1'b1;
                HEARTBEAT: led_d[n] = hb_q;
                STATUS:    led_d[n] = status_led;
                default:   led_d[n] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: doc/xilinx_status_led_ctrl.md
XILINX_STATUS_LED_CTRL -- requirements
Module: xilinx_status_led_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4: number of LED channels, legal range 1..8.
REQ-002 SHALL have parameter PRESCALE_W, default 24: prescaler width; one tick every 2^PRESCALE_W cycles.
REQ-003 SHALL have parameter HB_TICKS, default 8: ticks per heartbeat half-period, legal range 1..255.
REQ-004 SHALL have parameter EXIT_VALUE_W, default 32: exit value width, minimum 4.
REQ-005 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port led_mode_i, input, 2*NUM_LEDS: per-channel mode, channel n at bits [2n+1:2n].
REQ-008 SHALL have port exit_valid_i, input, 1: program-exit flag, asynchronous to clk_i.
REQ-009 SHALL have port exit_value_i, input, EXIT_VALUE_W: exit value, quasi-static while exit_valid_i is high.
REQ-010 SHALL have port led_o, output, NUM_LEDS: registered LED drives, 1 = lit.
REQ-011 SHALL have port exit_captured_o, output, 1: sticky flag, exit value captured.
REQ-012 SHALL have port exit_value_o, output, EXIT_VALUE_W: captured exit value.

Function
REQ-013 SHALL count a free-running PRESCALE_W-bit prescaler; tick is a 1-cycle pulse when the count equals all-ones; the count wraps to 0.
REQ-014 SHALL toggle a heartbeat bit on every HB_TICKS-th tick, counting ticks with an 8-bit counter that wraps at HB_TICKS-1.
REQ-015 SHALL pass exit_valid_i through a 2-flop synchroniser, then detect rising edges against a registered previous value.
REQ-016 SHALL set exit_captured_o and load exit_value_o from exit_value_i on the first detected rising edge only; the flag then asserts exactly 3 rising clock edges after exit_valid_i is first sampled high.
REQ-017 SHALL ignore all later exit_valid_i edges and value changes until reset.
REQ-018 SHALL run a status FSM with states RUN, PASS, FAIL_ON, FAIL_OFF and FAIL_GAP; reset state is RUN.
REQ-019 SHALL move RUN->PASS in the cycle after capture when exit_value_o == 0, otherwise RUN->FAIL_ON; this transition is not tick-aligned.
REQ-020 SHALL set blink count N = exit_value_o[3:0], or 16 when those bits are 0 and the value is non-zero.
REQ-021 SHALL sequence FAIL_ON (lit) -> FAIL_OFF after 1 tick; FAIL_OFF -> FAIL_ON after 1 tick while pulses sent < N, else FAIL_GAP; FAIL_GAP (dark) -> FAIL_ON after 4 ticks, clearing the pulse count; this repeats until reset.
REQ-022 SHALL hold PASS until reset.
REQ-023 SHALL set the status LED to the heartbeat bit in RUN, 1 in PASS, 1 in FAIL_ON, and 0 in FAIL_OFF and FAIL_GAP.
REQ-024 SHALL drive led_o[n] one cycle after led_mode_i is sampled: 00 gives 0, 01 gives 1, 10 gives the heartbeat bit, 11 gives the status LED.
REQ-025 SHALL let a mode change take effect on the next edge with no glitch beyond that edge.
REQ-026 SHALL give a tick coincident with capture no effect on the FSM until the following tick.

Reset
REQ-027 SHALL, on asserting rst_ni at any time including mid-blink, asynchronously clear the prescaler, tick counters, heartbeat, synchroniser, edge register, pulse count, exit_captured_o, exit_value_o and led_o, and return the FSM to RUN.
REQ-028 SHALL make release synchronous; the first tick occurs 2^PRESCALE_W cycles after release.

Structure
REQ-029 SHALL place the led_mode_e enum (OFF, ON, HEARTBEAT, STATUS), the status_state_e enum and the FAIL_GAP_TICKS=4 constant in package xilinx_status_led_pkg.
REQ-030 SHALL implement the synchroniser as sub-module xilinx_sync_2ff (parametrised reset value 0).

Verification (PRESCALE_W=2, HB_TICKS=2, so a tick every 4 cycles)
REQ-031 SHALL cover: modes 00/01/10 on channels 0..2 -> led_o[0]=0, led_o[1]=1, led_o[2] toggles every 8 cycles.
REQ-032 SHALL cover: exit_valid_i=1 with exit_value_i=0 -> exit_captured_o high on the 3rd edge, and a mode-11 LED solid 1 from the next cycle onward.
REQ-033 SHALL cover: exit_value_i=0x3 -> mode-11 LED shows 3 pulses of 4 cycles on / 4 cycles off, then 16 cycles dark, repeating.
REQ-034 SHALL cover: exit_value_i=0x20 -> 16 pulses per burst, with exit_value_o=0x20.
REQ-035 SHALL cover: after capture, drop exit_valid_i and re-raise it with value 0x5 -> exit_value_o unchanged, and no restart of the sequence.
REQ-036 SHALL cover: rst_ni low during FAIL_ON -> led_o=0 and exit_captured_o=0 immediately; after release the FSM is in RUN and a new capture works.
